// File: rtl/filtro_interp_pkg.sv
// Shared types and constants for the 8-tap fractional-sample interpolation filter.
package filtro_interp_pkg;

    typedef enum logic [1:0] {
        FRAC_INT = 2'd0,
        FRAC_Q   = 2'd1,
        FRAC_H   = 2'd2,
        FRAC_3Q  = 2'd3
    } frac_e;

    localparam int unsigned TAPS        = 8;
    localparam int unsigned NFRAC       = 4;
    localparam int unsigned PAIRS       = 4;
    localparam int unsigned SHIFT       = 6;
    localparam int unsigned ROUND_CONST = 32;
    localparam int unsigned FILL_W      = 4;

    typedef logic signed [7:0] coef_t;

    // Rows indexed by frac, columns by tap w0..w7; every row sums to 64.
    localparam coef_t COEF [NFRAC][TAPS] = '{
        '{ 8'sd0,  8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0,  8'sd0},
        '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1,  8'sd0},
        '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd4, -8'sd1},
        '{ 8'sd0,  8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd4, -8'sd1}
    };

endpackage

// File: rtl/filtro_interp_pipe_tap.sv
// Combinational weighted sum, split into pair sums (before S1) and the final
// round/shift (after S1). Products are constant shift/add networks muxed by frac.
module filtro8_tap
    import filtro_interp_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH = IN_WIDTH + 1,
    parameter int unsigned ROUND     = 0
) (
    input  logic signed [IN_WIDTH-1:0]  win      [TAPS],
    input  frac_e                       frac,
    output logic signed [IN_WIDTH+7:0]  pair_c   [PAIRS],
    input  logic signed [IN_WIDTH+7:0]  pair_q   [PAIRS],
    output logic signed [OUT_WIDTH-1:0] result_c
);

    localparam int unsigned ACC_W = IN_WIDTH + 8;
    localparam logic signed [ACC_W-1:0] RND = (ROUND != 0) ? ACC_W'(ROUND_CONST) : '0;

    // Constant coefficient -> sum of shifted copies, negated for negative taps.
    function automatic logic signed [ACC_W-1:0] mul_const(
        input logic signed [IN_WIDTH-1:0] x,
        input coef_t                      c
    );
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] acc;
        logic [7:0]              mag;
        xe  = ACC_W'(x);
        acc = '0;
        mag = c[7] ? 8'(-c) : 8'(c);
        for (int b = 0; b < 8; b++) begin
            if (mag[b]) acc = acc + (xe <<< b);
        end
        return c[7] ? -acc : acc;
    endfunction

    logic signed [ACC_W-1:0] prod [NFRAC][TAPS];
    logic signed [ACC_W-1:0] sum_c;

    always_comb begin
        for (int f = 0; f < NFRAC; f++) begin
            for (int t = 0; t < TAPS; t++) begin
                prod[f][t] = mul_const(win[t], COEF[f][t]);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < PAIRS; p++) begin
            pair_c[p] = prod[frac][2*p] + prod[frac][2*p+1];
        end
    end

    // Arithmetic shift gives floor division, so negative values truncate toward -inf.
    always_comb begin
        sum_c = RND;
        for (int p = 0; p < PAIRS; p++) begin
            sum_c = sum_c + pair_q[p];
        end
        result_c = OUT_WIDTH'(sum_c >>> SHIFT);
    end

endmodule

// File: rtl/filtro_interp_pipe.sv
// Streaming 8-tap fractional-sample interpolator: sliding window, two pipeline
// stages, ready/valid on both sides with a global stall.
module filtro_interp_pipe
    import filtro_interp_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH = IN_WIDTH + 1,
    parameter int unsigned ROUND     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic [1:0]                  in_frac,
    input  logic                        in_line_start,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    localparam int unsigned ACC_W = IN_WIDTH + 8;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

    logic signed [IN_WIDTH-1:0]  win_q  [TAPS];
    logic [FILL_W-1:0]           fill_q;
    logic [FILL_W-1:0]           fill_next_c;
    frac_e                       frac_q;
    logic                        v0_q;
    logic                        v1_q;
    logic signed [ACC_W-1:0]     pair_c [PAIRS];
    logic signed [ACC_W-1:0]     pair_q [PAIRS];
    logic signed [OUT_WIDTH-1:0] result_c;
    logic                        stall_c;
    logic                        accept_c;
    logic                        launch_c;

    // The whole pipeline freezes while the output holds an unaccepted result.
    assign stall_c  = out_valid && !out_ready;
    assign in_ready = !stall_c;
    assign accept_c = in_valid && in_ready;

    always_comb begin
        fill_next_c = fill_q;
        if (in_line_start) begin
            fill_next_c = FILL_W'(1);
        end else if (fill_q != FILL_FULL) begin
            fill_next_c = fill_q + FILL_W'(1);
        end
        launch_c = accept_c && (fill_next_c == FILL_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) begin
                win_q[t] <= '0;
            end
            for (int p = 0; p < PAIRS; p++) begin
                pair_q[p] <= '0;
            end
            fill_q    <= '0;
            frac_q    <= FRAC_INT;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall_c) begin
            if (accept_c) begin
                for (int t = 0; t < TAPS - 1; t++) begin
                    win_q[t] <= win_q[t+1];
                end
                win_q[TAPS-1] <= in_data;
                fill_q        <= fill_next_c;
                frac_q        <= frac_e'(in_frac);
            end
            // Bubbles advance like results; only the valid bits distinguish them.
            v0_q <= launch_c;
            for (int p = 0; p < PAIRS; p++) begin
                pair_q[p] <= pair_c[p];
            end
            v1_q      <= v0_q;
            out_valid <= v1_q;
            if (v1_q) begin
                out_data <= result_c;
            end
        end
    end

    filtro8_tap #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .ROUND     (ROUND)
    ) u_tap (
        .win      (win_q),
        .frac     (frac_q),
        .pair_c   (pair_c),
        .pair_q   (pair_q),
        .result_c (result_c)
    );

endmodule

// File: doc/filtro_interp_pipe.md
# filtro_interp_pipe

Streaming, pipelined 8-tap fractional-sample interpolation filter for the interpolator datapath. It generalises the fixed half-sample filter into a parametrised block with a sliding input window. It has per-sample selection of integer, quarter, half or three-quarter phase, optional rounding, and ready/valid backpressure on both sides. It sits between the reference-sample fetch stage and the prediction/output buffer.

## Interface
- `IN_WIDTH`, default 10: signed input sample width (DATA_WIDTH+2 of the 8-bit datapath).
- `OUT_WIDTH`, default `IN_WIDTH+1`: signed output width; fixed relation, not free.
- `ROUND`, default 0: 0 truncates (arithmetic shift only); 1 adds 32 before the shift.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  IN_WIDTH  signed sample.
- `in_frac`  in  2  phase for the output this sample completes: 0 integer, 1 quarter, 2 half, 3 three-quarter.
- `in_line_start`  in  1  this sample is the first of a new line.
- `out_valid`  out  1  output sample present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  OUT_WIDTH  signed filtered sample.

## Operation
- Accept = `in_valid && in_ready`. On accept, the window shifts: w0 is the oldest and w7 is the newest (`in_data`).
- Fill counter is 0..8 and saturates at 8. On accept with `in_line_start`=1 it is set to 1. Otherwise, on accept, it increments. The window is not cleared.
- An accepted sample launches a result only if the counter after the accept is 8. Otherwise it launches a bubble. The first 7 samples of a line produce no output.
- Coefficients are applied to w0..w7 and the coefficient sets sum to 64:
  - frac 0: 0,0,0,64,0,0,0,0
  - frac 1: -1,4,-10,58,17,-5,1,0
  - frac 2: -1,4,-11,40,40,-11,4,-1
  - frac 3: 0,1,-5,17,58,-10,4,-1
- `in_frac` is captured with the sample and travels with its result.
- Accumulator is signed, IN_WIDTH+8 bits, with no overflow possible (max coefficient magnitude sum is 112).
- `out_data` = (acc + (ROUND ? 32 : 0)) >>> 6, taking the low OUT_WIDTH bits. This result always fits.
- Multiplies are shift/add only; no hardware multipliers.

## Timing
- Reset: `out_valid`=0, `out_data`=0, `in_ready`=1, fill counter=0, window=0, pipeline valids=0.
- Pipeline: window register → S1 (four partial sums, registered) → S2 (final sum, round, shift into the output register).
- Latency: a result whose completing sample is accepted at edge E shows `out_valid`=1 after edge E+2.
- Stall = `out_valid && !out_ready`. While stalled:
  - `in_ready`=0.
  - The window, S1, S2 and the counter all hold.
  - `out_data` stays stable.
- Bubbles are not collapsed.
- Throughput is 1 sample per cycle with no stall.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.
- `in_line_start` with `in_valid`=0 is ignored.
- Line start in the same cycle as a stall: the sample is not accepted, so it has no effect.
- Reset mid-operation: all in-flight results are discarded immediately. No `out_valid` is asserted until 8 new samples have been accepted.

## Structure
- Package `filtro_interp_pkg`:
  - frac enum (FRAC_INT, FRAC_Q, FRAC_H, FRAC_3Q).
  - 4×8 signed coefficient table.
  - shift constant 6 and round constant 32.
- Sub-module `filtro8_tap`: combinational 8-input weighted sum for a selected frac, split at the S1 register boundary into pair sums and a final sum. The top level owns the handshake, the counter, the window and the pipeline registers.

## Test plan
- DC level: 8+ samples of 100, with each frac in turn → every output is 100. Repeat with -100 → every output is -100.
- Ramp 0..7 after a line start, frac 2:
  - ROUND=0 → out 3 (acc 224).
  - ROUND=1 → out 4.
  - Same ramp with frac 1 → out 3 (acc 207).
- Impulse: a single 10 among zeros, frac 2, ROUND=0 → outputs -1, 0, -2, 6, 6, -2, 0, -1. Negative truncation must be arithmetic.
- Backpressure: continuous input, `out_ready` low for 5 cycles mid-stream →
  - `in_ready` is low for those cycles.
  - `out_data` is held.
  - No sample is lost or duplicated against the model.
- Line start after 12 samples → no outputs for the next 7 accepts, then output resumes from the new line's window.
- Reset asserted while 2 results are in flight → `out_valid` drops immediately and stays low until 8 new accepts plus 2 cycles.
